bar_peak_sequencer: RTL and testbench
=====================================

BAR_PEAK_SEQUENCER -- requirements
Module: bar_peak_sequencer

Interface
REQ-001 Parameter NUM_BARS, default 200, sets the number of bar columns per channel.
REQ-002 Parameter HOLD_FRAMES, default 30, sets how many frames a peak marker holds before falling.
REQ-003 Parameter MAX_H, default 96, sets the maximum bar/top height.
REQ-004 The block SHALL use one clock, Clock; reset is Reset, synchronous and active-high.
REQ-005 Ports: Clock in 1 system clock; Reset in 1 sync active-high reset.
REQ-006 Ports: FrameStart in 1 pulse, begin one full redraw (L then R).
REQ-007 Ports: DrawTopEn in 1 global enable for peak markers.
REQ-008 Ports: MagReq out 1; MagAddr out 9 ({ch, bar}-linear index ch*NUM_BARS+bar); MagValid in 1; MagData in 8 (raw magnitude).
REQ-009 Ports: LRChange out 1 pulse; Start out 1 pulse; Bar out 7; Top out 7; DrawTop out 1; End in 1; Busy in 1 (draw-stage handshake).
REQ-010 Ports: FrameBusy out 1; FrameDone out 1 pulse.

Function
REQ-011 FSM states: IDLE, CHG, REQ, WMAG, CALC, ISSUE, WEND, NEXT, DONE.
REQ-012 IDLE: on FrameStart go CHG with ch=0, bar=0; FrameStart outside IDLE SHALL be ignored.
REQ-013 CHG: LRChange=1 for exactly one cycle, then REQ; issued once per channel before its first bar.
REQ-014 REQ: MagReq=1 with MagAddr valid; MagReq SHALL stay high until MagValid is sampled high (WMAG merged in same cycle allowed); MagAddr stable throughout.
REQ-015 Height h = min(MagData, MAX_H), 7-bit saturating; values >= MAX_H give MAX_H.
REQ-016 CALC (one cycle) reads peak entry {top, hold} for index and writes back: if h >= top then top=h, hold=HOLD_FRAMES; else if hold>0 then hold-1; else top=top-1 saturating at 0.
REQ-017 Bar<=h and Top<=new top registered in CALC; DrawTop<=DrawTopEn && (new top > h).
REQ-018 ISSUE: wait until Busy=0, then Start=1 for one cycle; Bar/Top/DrawTop SHALL remain stable from Start until End is seen.
REQ-019 WEND: wait End=1; then NEXT.
REQ-020 NEXT: bar==NUM_BARS-1 -> (ch==0 ? ch=1, bar=0, CHG : DONE); else bar+1, REQ.
REQ-021 DONE: FrameDone=1 one cycle, then IDLE; FrameBusy=1 in every state except IDLE.
REQ-022 End arriving in any state other than WEND SHALL be ignored.
REQ-023 Exactly 2 LRChange and 2*NUM_BARS Start pulses SHALL occur per frame.
REQ-024 hold counter width = clog2(HOLD_FRAMES+1); top width 7.

Reset
REQ-025 Reset SHALL force IDLE; LRChange, Start, MagReq, FrameDone, FrameBusy, DrawTop = 0; Bar, Top, MagAddr = 0.
REQ-026 Reset SHALL clear all 2*NUM_BARS peak entries to top=0, hold=0; clearing MAY take up to 2*NUM_BARS cycles via a sweep, during which FrameStart is ignored and FrameBusy=1.
REQ-027 Reset mid-frame SHALL abort without further Start/LRChange pulses.

Structure
REQ-028 Shared package: MAX_H, NUM_BARS default, state encoding, entry width constants.
REQ-029 Sub-module peak_mem: single-port 2*NUM_BARS x (7+hold) storage, sync read/write, one read-modify-write per CALC.

Verification
REQ-030 Single frame, NUM_BARS=4, MagData=50 all, End 3 cycles after Start -> 2 LRChange, 8 Start, Bar=50, Top=50, DrawTop=0, one FrameDone.
REQ-031 Saturation: MagData=200 -> Bar=96, Top=96; MagData=96 -> Bar=96.
REQ-032 Peak decay: bar0 frame1 mag=80, then mag=10 for HOLD_FRAMES+3 frames -> Top=80 for HOLD_FRAMES frames, then 79,78,77; DrawTop=1 when enabled.
REQ-033 Handshake: Busy held high 10 cycles before ISSUE -> Start delayed until Busy=0; MagValid delayed 5 cycles -> MagReq/MagAddr held stable.
REQ-034 Stray End in REQ and FrameStart mid-frame -> no effect on sequence or counts.
REQ-035 Reset asserted at bar 2 of ch1 -> outputs zero next cycle, peak entries cleared, next frame Top equals new h.

Source files
------------

// File: rtl/bar_peak_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the bar/peak redraw sequencer.
package bar_peak_sequencer_pkg;

    localparam int unsigned MAX_H           = 96;
    localparam int unsigned NUM_BARS_DEF    = 200;
    localparam int unsigned HOLD_FRAMES_DEF = 30;
    localparam int unsigned TOP_W           = 7;
    localparam int unsigned MAG_W           = 8;
    localparam int unsigned ADDR_W          = 9;

    typedef enum logic [3:0] {
        IDLE,
        CHG,
        REQ,
        WMAG,
        CALC,
        ISSUE,
        WEND,
        NEXT,
        DONE
    } seqState_e;

    // Width of the per-entry hold counter
    function automatic int unsigned holdWidth(input int unsigned holdFrames);
        return (holdFrames > 0) ? $clog2(holdFrames + 1) : 1;
    endfunction

    // Raw magnitude clipped to the drawable height range
    function automatic logic [TOP_W-1:0] satHeight(input logic [MAG_W-1:0] mag);
        if (mag >= MAG_W'(MAX_H)) begin
            return TOP_W'(MAX_H);
        end
        return mag[TOP_W-1:0];
    endfunction

endpackage

// File: rtl/bar_peak_sequencer_peak_mem.sv
// Peak-marker storage: one {top, hold} entry per bar per channel.
module bar_peak_sequencer_peak_mem
    import bar_peak_sequencer_pkg::*;
#(
    parameter  int unsigned DEPTH = 2 * NUM_BARS_DEF,
    parameter  int unsigned WIDTH = TOP_W + 5,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             Clock,
    input  logic [IDX_W-1:0] Addr,
    input  logic             WrEn,
    input  logic [WIDTH-1:0] WrData,
    output logic [WIDTH-1:0] RdData
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Single-port read-first RAM; read data appears the cycle after the address
    always_ff @(posedge Clock) begin
        if (WrEn) begin
            mem[Addr] <= WrData;
        end
        RdData <= mem[Addr];
    end

endmodule

// File: rtl/bar_peak_sequencer.sv
// Walks every bar of both channels once per frame: fetch magnitude, update the
// peak marker, hand the bar to the draw stage and wait for it to finish.
module bar_peak_sequencer
    import bar_peak_sequencer_pkg::*;
#(
    parameter int unsigned NUM_BARS    = NUM_BARS_DEF,
    parameter int unsigned HOLD_FRAMES = HOLD_FRAMES_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              FrameStart,
    input  logic              DrawTopEn,
    output logic              MagReq,
    output logic [ADDR_W-1:0] MagAddr,
    input  logic              MagValid,
    input  logic [MAG_W-1:0]  MagData,
    output logic              LRChange,
    output logic              Start,
    output logic [TOP_W-1:0]  Bar,
    output logic [TOP_W-1:0]  Top,
    output logic              DrawTop,
    input  logic              End,
    input  logic              Busy,
    output logic              FrameBusy,
    output logic              FrameDone
);

    localparam int unsigned DEPTH   = 2 * NUM_BARS;
    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam int unsigned HOLD_W  = holdWidth(HOLD_FRAMES);
    localparam int unsigned ENTRY_W = TOP_W + HOLD_W;
    localparam int unsigned BAR_W   = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;

    seqState_e          state;
    logic               ch;
    logic [BAR_W-1:0]   bar;
    logic [TOP_W-1:0]   height;
    logic               clearing;
    logic [IDX_W-1:0]   clrIdx;

    logic [IDX_W-1:0]   memAddr;
    logic               memWrEn;
    logic [ENTRY_W-1:0] memWrData;
    logic [ENTRY_W-1:0] memRdData;
    logic [TOP_W-1:0]   curTop;
    logic [TOP_W-1:0]   newTop;
    logic [HOLD_W-1:0]  curHold;
    logic [HOLD_W-1:0]  newHold;

    // Linear magnitude/peak index for a channel and bar
    function automatic logic [ADDR_W-1:0] barAddr(input logic chSel, input logic [BAR_W-1:0] barSel);
        return ADDR_W'(barSel) + (chSel ? ADDR_W'(NUM_BARS) : ADDR_W'(0));
    endfunction

    bar_peak_sequencer_peak_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) peakMem (
        .Clock  (Clock),
        .Addr   (memAddr),
        .WrEn   (memWrEn),
        .WrData (memWrData),
        .RdData (memRdData)
    );

    // Peak marker rule: new high resets the hold, otherwise hold then fall by one
    always_comb begin
        curTop  = memRdData[ENTRY_W-1:HOLD_W];
        curHold = memRdData[HOLD_W-1:0];
        newTop  = curTop;
        newHold = curHold;
        if (height >= curTop) begin
            newTop  = height;
            newHold = HOLD_W'(HOLD_FRAMES);
        end else if (curHold != '0) begin
            newHold = curHold - HOLD_W'(1);
        end else if (curTop != '0) begin
            newTop = curTop - TOP_W'(1);
        end
    end

    // Memory port: sweep index while clearing, otherwise the bar being fetched
    always_comb begin
        memAddr   = clearing ? clrIdx : IDX_W'(MagAddr);
        memWrEn   = clearing || (state == CALC);
        memWrData = clearing ? '0 : {newTop, newHold};
    end

    // Frame sequencer with registered handshake outputs and post-reset clear sweep
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            ch        <= 1'b0;
            bar       <= '0;
            height    <= '0;
            clearing  <= 1'b1;
            clrIdx    <= '0;
            MagReq    <= 1'b0;
            MagAddr   <= '0;
            LRChange  <= 1'b0;
            Start     <= 1'b0;
            Bar       <= '0;
            Top       <= '0;
            DrawTop   <= 1'b0;
            FrameBusy <= 1'b0;
            FrameDone <= 1'b0;
        end else begin
            LRChange  <= 1'b0;
            Start     <= 1'b0;
            FrameDone <= 1'b0;

            if (clearing) begin
                clrIdx <= clrIdx + IDX_W'(1);
                if (clrIdx == IDX_W'(DEPTH - 1)) begin
                    clearing  <= 1'b0;
                    FrameBusy <= 1'b0;
                end else begin
                    FrameBusy <= 1'b1;
                end
            end

            unique case (state)
                IDLE: begin
                    if (FrameStart && !clearing) begin
                        ch        <= 1'b0;
                        bar       <= '0;
                        LRChange  <= 1'b1;
                        FrameBusy <= 1'b1;
                        state     <= CHG;
                    end
                end
                CHG: begin
                    MagReq  <= 1'b1;
                    MagAddr <= barAddr(ch, bar);
                    state   <= REQ;
                end
                REQ, WMAG: begin
                    if (MagValid) begin
                        MagReq <= 1'b0;
                        height <= satHeight(MagData);
                        state  <= CALC;
                    end else begin
                        state <= WMAG;
                    end
                end
                CALC: begin
                    Bar     <= height;
                    Top     <= newTop;
                    DrawTop <= DrawTopEn && (newTop > height);
                    state   <= ISSUE;
                end
                ISSUE: begin
                    if (!Busy) begin
                        Start <= 1'b1;
                        state <= WEND;
                    end
                end
                WEND: begin
                    if (End) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (bar == BAR_W'(NUM_BARS - 1)) begin
                        if (!ch) begin
                            ch       <= 1'b1;
                            bar      <= '0;
                            LRChange <= 1'b1;
                            state    <= CHG;
                        end else begin
                            FrameDone <= 1'b1;
                            state     <= DONE;
                        end
                    end else begin
                        bar     <= bar + BAR_W'(1);
                        MagReq  <= 1'b1;
                        MagAddr <= barAddr(ch, bar + BAR_W'(1));
                        state   <= REQ;
                    end
                end
                DONE: begin
                    FrameBusy <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bar_peak_sequencer.sv
// Scoreboard bench for bar_peak_sequencer with a small magnitude source and draw stage.
module tb_bar_peak_sequencer;

    localparam int NB = 4;
    localparam int HF = 30;
    localparam int NE = 2 * NB;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       FrameStart;
    logic       DrawTopEn;
    logic       MagReq;
    logic [8:0] MagAddr;
    logic       MagValid;
    logic [7:0] MagData;
    logic       LRChange;
    logic       Start;
    logic [6:0] Bar;
    logic [6:0] Top;
    logic       DrawTop;
    logic       End;
    logic       Busy;
    logic       FrameBusy;
    logic       FrameDone;
    logic       endDrv;
    logic       strayEnd;

    assign End = endDrv | strayEnd;

    always #5 Clock = ~Clock;

    bar_peak_sequencer #(
        .NUM_BARS    (NB),
        .HOLD_FRAMES (HF)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .FrameStart (FrameStart),
        .DrawTopEn  (DrawTopEn),
        .MagReq     (MagReq),
        .MagAddr    (MagAddr),
        .MagValid   (MagValid),
        .MagData    (MagData),
        .LRChange   (LRChange),
        .Start      (Start),
        .Bar        (Bar),
        .Top        (Top),
        .DrawTop    (DrawTop),
        .End        (End),
        .Busy       (Busy),
        .FrameBusy  (FrameBusy),
        .FrameDone  (FrameDone)
    );

    typedef struct {
        int bar;
        int top;
        bit dt;
    } exp_t;

    exp_t expQ[$];
    int   topLog[$];
    int   barLog[$];
    bit   dtLog[$];
    int   mtop[NE];
    int   mhold[NE];
    int   magTab[NE];
    int   magDelay = 0;
    int   endDelay = 3;
    int   addrSeq  = 0;
    int   checks   = 0;
    int   failures = 0;
    int   startCnt = 0;
    int   lrCnt    = 0;
    int   doneCnt  = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic modelClear();
        for (int i = 0; i < NE; i++) begin
            mtop[i]  = 0;
            mhold[i] = 0;
        end
        expQ.delete();
    endtask

    task automatic setMag(input int v);
        for (int i = 0; i < NE; i++) magTab[i] = v;
    endtask

    task automatic checkZero(input string tag);
        check({tag, "_magreq"},    int'(MagReq),    0);
        check({tag, "_start"},     int'(Start),     0);
        check({tag, "_lrchange"},  int'(LRChange),  0);
        check({tag, "_framebusy"}, int'(FrameBusy), 0);
        check({tag, "_framedone"}, int'(FrameDone), 0);
        check({tag, "_drawtop"},   int'(DrawTop),   0);
        check({tag, "_bar"},       int'(Bar),       0);
        check({tag, "_top"},       int'(Top),       0);
        check({tag, "_magaddr"},   int'(MagAddr),   0);
    endtask

    // Magnitude source: answers each request after magDelay cycles and queues the expectation
    initial begin
        int addr;
        int h;
        bit aborted;
        MagValid = 1'b0;
        MagData  = '0;
        forever begin
            @(negedge Clock);
            if (MagReq) begin
                addr    = int'(MagAddr);
                aborted = 1'b0;
                check("mag_addr_order", addr, addrSeq);
                for (int i = 0; i < magDelay && !aborted; i++) begin
                    @(negedge Clock);
                    if (Reset) begin
                        aborted = 1'b1;
                    end else begin
                        check("magreq_held", int'(MagReq), 1);
                        check("magaddr_stable", int'(MagAddr), addr);
                    end
                end
                if (!aborted && !Reset && addr < NE) begin
                    h = (magTab[addr] > 96) ? 96 : magTab[addr];
                    if (h >= mtop[addr]) begin
                        mtop[addr]  = h;
                        mhold[addr] = HF;
                    end else if (mhold[addr] > 0) begin
                        mhold[addr] = mhold[addr] - 1;
                    end else if (mtop[addr] > 0) begin
                        mtop[addr] = mtop[addr] - 1;
                    end
                    expQ.push_back('{bar: h, top: mtop[addr], dt: (DrawTopEn && (mtop[addr] > h))});
                    addrSeq  = (addrSeq + 1) % NE;
                    MagData  = 8'(magTab[addr]);
                    MagValid = 1'b1;
                    @(negedge Clock);
                    MagValid = 1'b0;
                end
            end
        end
    end

    // Draw stage monitor: pops the scoreboard on every Start and answers with End
    initial begin
        exp_t e;
        int   b;
        int   t;
        bit   d;
        endDrv = 1'b0;
        forever begin
            @(negedge Clock);
            if (Start) begin
                startCnt++;
                b = int'(Bar);
                t = int'(Top);
                d = DrawTop;
                topLog.push_back(t);
                barLog.push_back(b);
                dtLog.push_back(d);
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_start actual=Start required=none (t=%0t)", $time);
                end else begin
                    e = expQ.pop_front();
                    check("bar", b, e.bar);
                    check("top", t, e.top);
                    check("drawtop", int'(d), int'(e.dt));
                end
                for (int i = 0; i < endDelay; i++) begin
                    @(negedge Clock);
                    if (Reset) break;
                    check("start_pulse", int'(Start), 0);
                    check("draw_stable", (int'(Bar) << 8) | (int'(Top) << 1) | int'(DrawTop),
                          (b << 8) | (t << 1) | int'(d));
                end
                endDrv = 1'b1;
                @(negedge Clock);
                endDrv = 1'b0;
            end
        end
    end

    // Pulse counters for frame-level accounting
    initial begin
        forever begin
            @(negedge Clock);
            if (LRChange) lrCnt++;
            if (FrameDone) doneCnt++;
        end
    end

    task automatic runFrame(input string tag, input int busyHold, input bit stray);
        int s0;
        int l0;
        int d0;
        int w;
        s0 = startCnt;
        l0 = lrCnt;
        d0 = doneCnt;
        addrSeq = 0;
        if (busyHold > 0) Busy = 1'b1;
        FrameStart = 1'b1;
        @(negedge Clock);
        FrameStart = 1'b0;
        if (busyHold > 0) begin
            cyc(busyHold);
            check({tag, "_no_start_while_busy"}, startCnt - s0, 0);
            Busy = 1'b0;
        end
        if (stray) begin
            w = 0;
            while (!MagReq && w < 200) begin
                @(negedge Clock);
                w++;
            end
            check({tag, "_reached_req"}, int'(MagReq), 1);
            strayEnd = 1'b1;
            @(negedge Clock);
            strayEnd = 1'b0;
            cyc(15);
            FrameStart = 1'b1;
            @(negedge Clock);
            FrameStart = 1'b0;
        end
        w = 0;
        while (doneCnt == d0 && w < 1000) begin
            @(negedge Clock);
            w++;
        end
        cyc(6);
        check({tag, "_framedone"}, doneCnt - d0, 1);
        check({tag, "_lrchange"}, lrCnt - l0, 2);
        check({tag, "_starts"}, startCnt - s0, 2 * NB);
        check({tag, "_idle_busy"}, int'(FrameBusy), 0);
        check({tag, "_sb_drained"}, expQ.size(), 0);
    endtask

    // Directed sequence
    initial begin
        int w;
        int s0;
        int l0;
        int expTop;
        Reset      = 1'b1;
        FrameStart = 1'b0;
        DrawTopEn  = 1'b0;
        Busy       = 1'b0;
        strayEnd   = 1'b0;
        setMag(50);
        modelClear();

        cyc(3);
        checkZero("reset");
        Reset = 1'b0;
        cyc(1);
        check("sweep_busy", int'(FrameBusy), 1);
        w = 0;
        while (FrameBusy && w < 50) begin
            @(negedge Clock);
            w++;
        end
        check("sweep_done", int'(FrameBusy), 0);

        // Uniform magnitude 50
        runFrame("basic", 0, 1'b0);
        check("basic_bar_last", barLog[$], 50);
        check("basic_top_last", topLog[$], 50);

        // Peak hold then decay on bar 0
        DrawTopEn = 1'b1;
        for (int f = 0; f < HF + 4; f++) begin
            setMag((f == 0) ? 80 : 10);
            topLog.delete();
            dtLog.delete();
            barLog.delete();
            runFrame("decay", 0, 1'b0);
            expTop = (f <= HF) ? 80 : 80 - (f - HF);
            check("decay_top_bar0", topLog[0], expTop);
            check("decay_drawtop_bar0", int'(dtLog[0]), (f > 0) ? 1 : 0);
        end

        // Height saturation
        DrawTopEn = 1'b0;
        setMag(200);
        topLog.delete();
        barLog.delete();
        runFrame("sat200", 0, 1'b0);
        check("sat200_bar", barLog[0], 96);
        check("sat200_top", topLog[0], 96);
        setMag(96);
        topLog.delete();
        barLog.delete();
        runFrame("sat96", 0, 1'b0);
        check("sat96_bar", barLog[0], 96);
        check("sat96_top", topLog[7], 96);

        // Busy back-pressure and slow magnitude source
        magDelay = 5;
        runFrame("handshake", 10, 1'b0);

        // Stray End during fetch and FrameStart mid-frame
        magDelay = 2;
        runFrame("stray", 0, 1'b1);

        // Reset at ch1 bar2
        magDelay = 3;
        addrSeq  = 0;
        FrameStart = 1'b1;
        @(negedge Clock);
        FrameStart = 1'b0;
        w = 0;
        while (!(MagReq && int'(MagAddr) == NB + 2) && w < 1000) begin
            @(negedge Clock);
            w++;
        end
        check("reached_ch1_bar2", int'(MagAddr), NB + 2);
        Reset = 1'b1;
        @(negedge Clock);
        checkZero("midreset");
        s0 = startCnt;
        l0 = lrCnt;
        @(negedge Clock);
        Reset = 1'b0;
        modelClear();
        @(negedge Clock);
        check("midreset_sweep_busy", int'(FrameBusy), 1);
        FrameStart = 1'b1;
        @(negedge Clock);
        FrameStart = 1'b0;
        w = 0;
        while (FrameBusy && w < 50) begin
            @(negedge Clock);
            w++;
        end
        cyc(3);
        check("midreset_sweep_done", int'(FrameBusy), 0);
        check("midreset_no_starts", startCnt - s0, 0);
        check("midreset_no_lrchange", lrCnt - l0, 0);

        // Cleared peaks: Top follows the new height
        magDelay  = 0;
        DrawTopEn = 1'b1;
        setMag(10);
        topLog.delete();
        dtLog.delete();
        runFrame("post_reset", 0, 1'b0);
        check("post_reset_top", topLog[0], 10);
        check("post_reset_drawtop", int'(dtLog[0]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop if the sequence stalls beyond all per-step bounds
    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
